uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single transmit byte stream of the UART core between `PORTS` independent AXI-Stream byte sources. It sits between the software-facing requesters (register interface, debug console, DMA, and so on) and the UART `s_axis` input. Grant is held per packet: it is released when the beat carrying `tlast` is accepted, or on an idle timeout. The output is registered, so the block drives the UART through a one-deep output buffer.

## Interface
- `PORTS`, 4: number of requesters, 1..16.
- `DATA_WIDTH`, 8: byte width; must match the UART `DATA_WIDTH`.
- `TIMEOUT`, 255: consecutive granted-idle cycles before forced release; 0 disables the timeout.
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous reset, active-high.
- `s_tdata`  in  PORTS*DATA_WIDTH  requester data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `s_tvalid`  in  PORTS  per-port valid.
- `s_tlast`  in  PORTS  per-port end-of-packet.
- `s_tready`  out  PORTS  per-port ready; at most one bit is high.
- `m_tdata`  out  DATA_WIDTH  to UART `s_axis_tdata`.
- `m_tvalid`  out  1  to UART `s_axis_tvalid`.
- `m_tready`  in  1  from UART `s_axis_tready`.
- `grant_valid`  out  1  a port currently holds the grant.
- `grant_idx`  out  max(1,clog2(PORTS))  index of the granted port.
- `timeout_pulse`  out  1  one-cycle strobe on forced release.

## Operation
- States:
  - IDLE: no grant.
  - BUSY: grant is held by `grant_idx`.
- IDLE:
  - If any `s_tvalid` is high, select the first valid port searching upward from `last_grant+1`, wrapping modulo PORTS.
  - Register the selection into `grant_idx`, set `grant_valid=1`, and go to BUSY.
  - `s_tready` stays all-zero while in IDLE.
- BUSY:
  - `s_tready[grant_idx] = !m_tvalid || m_tready`. All other ready bits are 0.
  - A beat is accepted when `s_tvalid[g] && s_tready[g]`. On acceptance, load `m_tdata` and set `m_tvalid=1`.
  - If the accepted beat has `s_tlast[g]=1`: go to IDLE, set `last_grant<=g`, clear `grant_valid`.
- Output buffer:
  - `m_tvalid` is cleared on `m_tready` unless it is reloaded in the same cycle.
  - The buffer drains independently of the state, so it may still hold the final byte while the block is in IDLE.
- Timeout (only when `TIMEOUT>0`):
  - The counter increments each BUSY cycle with `s_tvalid[g]=0`.
  - It clears on any accepted beat and on entry to BUSY.
  - When the count reaches `TIMEOUT`: go to IDLE, set `last_grant<=g`, pulse `timeout_pulse`.
  - Counter width is clog2(TIMEOUT+1). It saturates and never wraps.
- Non-granted ports are never stalled for data corruption. They simply wait, and their `s_tdata` is ignored.
- `PORTS=1`: the arbitration always picks port 0, and the rest of the behaviour is unchanged.

## Timing
- Reset values: `m_tvalid=0`, `m_tdata=0`, `s_tready=0`, `grant_valid=0`, `grant_idx=0`, `timeout_pulse=0`, counter 0, state IDLE.
- After reset, `last_grant=PORTS-1`, so port 0 has first priority.
- Request to grant: `s_tvalid` high in IDLE at cycle n gives `grant_valid` and `s_tready` high at n+1, provided the output buffer is empty.
- Accept to output: a beat accepted at cycle n appears on `m_tdata`/`m_tvalid` at n+1.
- Full throughput: with `m_tready` held high, one beat is accepted per cycle.
- Packet switch: a `tlast` accepted at n puts the block in IDLE at n+1. The next grant is at n+2. There is a 1-cycle bubble on `s_tready`.
- Simultaneous timeout expiry and beat acceptance: acceptance wins, the counter clears, and there is no pulse.
- Simultaneous `m_tready` and a new accept: `m_tvalid` stays 1 and the data is replaced.
- `rst` mid-packet: all state is dropped on the next edge, including any buffered byte. The UART is expected to be reset in the same cycle.
- `timeout_pulse` is high for exactly the one cycle in which the state returns to IDLE.

## Structure
- Shared package `uart_defs`:
  - state encoding localparams `ST_IDLE` and `ST_BUSY`;
  - `clog2` function, reused by the UART register blocks.
- Sub-module `rr_pick`:
  - purely combinational round-robin picker;
  - inputs: request vector and `last_grant`; outputs: `any` and `idx`;
  - parameterised by `PORTS`.
- The top level holds the state machine, the timeout counter, and the output register.

## Test plan
- Reset, then port 0 sends the 3-byte packet 0x41,0x42,0x43 (tlast on 0x43) with `m_tready=1`:
  - `m_tdata` sequence is 41,42,43 on consecutive cycles starting 2 cycles after `tvalid`;
  - `grant_idx=0`, then `grant_valid` drops.
- Ports 0, 1 and 3 all request continuously, each sending 1-byte packets (0x10+i):
  - output order is 10,11,13,10,11,13;
  - port 2 never gets `s_tready`.
- Port 2 packet 0xA0,0xA1 with `m_tready` toggling 1,0,1,0:
  - no byte is lost or duplicated;
  - `s_tready[2]` is low whenever `m_tvalid && !m_tready`.
- `TIMEOUT=4`: port 1 sends 0x55 without tlast and then drops `tvalid`:
  - `timeout_pulse` is high exactly 4 idle cycles later;
  - port 2, already requesting, is granted on the next cycle.
- `rst` asserted mid-packet (after byte 2 of 4) on port 3:
  - next cycle: `m_tvalid=0`, `grant_valid=0`, all `s_tready=0`;
  - the next request from port 3 is granted with port-0-first priority.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART definitions: arbiter state encoding and a constant-foldable clog2.
// No logic; imported by the arbiter and the UART register blocks.
package uart_defs;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef enum logic [0:0] {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester streams, UART-side stream and grant status for uart_tx_arbiter.
// master is the arbiter's view; slave is the requesters/UART side.
interface uart_tx_arbiter_if
  import uart_defs::*;
#(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8,
  localparam int IDX_W     = (clog2(PORTS) > 0) ? clog2(PORTS) : 1
);

  logic [PORTS*DATA_WIDTH-1:0] s_tdata;
  logic [PORTS-1:0]            s_tvalid;
  logic [PORTS-1:0]            s_tlast;
  logic [PORTS-1:0]            s_tready;
  logic [DATA_WIDTH-1:0]       m_tdata;
  logic                        m_tvalid;
  logic                        m_tready;
  logic                        grant_valid;
  logic [IDX_W-1:0]            grant_idx;
  logic                        timeout_pulse;

  modport master (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, grant_valid, grant_idx, timeout_pulse
  );

  modport slave (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, grant_valid, grant_idx, timeout_pulse
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester searching upward from last_grant+1, wrapping.
// Zero latency; no flow control.
module rr_pick
  import uart_defs::*;
#(
  parameter int PORTS  = 4,
  localparam int IDX_W = (clog2(PORTS) > 0) ? clog2(PORTS) : 1
) (
  input  logic [PORTS-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  int p;

  // Walk the offsets from farthest to nearest so the nearest requester is written last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    p   = 0;
    for (int k = PORTS; k >= 1; k--) begin
      p = (int'(last_grant) + k) % PORTS;
      if (req[p]) begin
        any = 1'b1;
        idx = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin mux of PORTS byte streams onto the UART: grant 1 cycle after request, data 1 cycle after accept.
// Backpressure: the granted port sees ready only while the one-deep output buffer is empty or draining.
module uart_tx_arbiter
  import uart_defs::*;
#(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255,
  localparam int IDX_W     = (clog2(PORTS) > 0) ? clog2(PORTS) : 1,
  localparam int CNT_W     = (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  vld_q;

  logic                  pick_any;
  logic [IDX_W-1:0]      pick_idx;
  logic                  g_vld;
  logic                  g_last;
  logic                  g_rdy;
  logic                  accept;
  logic [DATA_WIDTH-1:0] g_dat;

  rr_pick #(.PORTS(PORTS)) u_pick (
    .req        (bus.s_tvalid),
    .last_grant (last_q),
    .any        (pick_any),
    .idx        (pick_idx)
  );

  assign g_vld  = bus.s_tvalid[grant_q];
  assign g_last = bus.s_tlast[grant_q];
  assign g_dat  = bus.s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign g_rdy  = (state_q == S_BUSY) && (!vld_q || bus.m_tready);
  assign accept = g_rdy && g_vld;

  always_comb begin
    bus.s_tready = '0;
    if (state_q == S_BUSY) begin
      bus.s_tready[grant_q] = !vld_q || bus.m_tready;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          state_d = S_BUSY;
          grant_d = pick_idx;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        if (accept) begin
          cnt_d = '0;
          if (g_last) begin
            state_d = S_IDLE;
            last_d  = grant_q;
          end
        end else if (TIMEOUT > 0 && !g_vld) begin
          // Expire on the idle cycle that brings the count up to TIMEOUT.
          if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
            state_d = S_IDLE;
            last_d  = grant_q;
            tmo_d   = 1'b1;
            cnt_d   = CNT_W'(TIMEOUT);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(PORTS - 1);
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      data_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      if (accept) begin
        data_q <= g_dat;
        vld_q  <= 1'b1;
      end else if (bus.m_tready) begin
        vld_q  <= 1'b0;
      end
    end
  end

  assign bus.m_tdata       = data_q;
  assign bus.m_tvalid      = vld_q;
  assign bus.grant_valid   = (state_q == S_BUSY);
  assign bus.grant_idx     = grant_q;
  assign bus.timeout_pulse = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (PORTS=4, TIMEOUT=4): directed tables, hand-written corner sequences,
// then randomized traffic against a cycle-level reference model.
module tb_uart_tx_arbiter;

  localparam int P   = 4;
  localparam int DW  = 8;
  localparam int TMO = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  uart_tx_arbiter_if #(.PORTS(P), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(.PORTS(P), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          pre_rst;
    logic [3:0]  vld;
    logic [3:0]  last;
    logic [31:0] dat;
    logic        mrdy;
    logic [3:0]  e_rdy;
    logic        e_mvld;
    logic [7:0]  e_mdat;
    logic        e_gvld;
    logic [1:0]  e_gidx;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(bit pr, logic [3:0] vl, logic [3:0] la, logic [31:0] d, logic mr,
                             logic [3:0] er, logic emv, logic [7:0] emd, logic egv, logic [1:0] egi);
    vec_t r;
    r.pre_rst = pr; r.vld = vl; r.last = la; r.dat = d; r.mrdy = mr;
    r.e_rdy = er; r.e_mvld = emv; r.e_mdat = emd; r.e_gvld = egv; r.e_gidx = egi;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] vl, input logic [3:0] la, input logic [31:0] d, input logic mr);
    bus.s_tvalid = vl;
    bus.s_tlast  = la;
    bus.s_tdata  = d;
    bus.m_tready = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b0, 4'b0, 32'h0, 1'b1);
    tick();
    rst = 1'b0;
  endtask

  // Reference model: owner of the grant (-1 = nobody), last packet owner, one-byte buffer, idle run length.
  int         m_owner, m_last, m_gidx, m_idle;
  bit         m_bvld, m_pulse;
  logic [7:0] m_bdat;

  task automatic m_reset();
    m_owner = -1; m_last = P - 1; m_gidx = 0; m_idle = 0;
    m_bvld = 0; m_pulse = 0; m_bdat = 8'h00;
  endtask

  task automatic model_check(input int c);
    logic [3:0] er;
    er = 4'b0;
    if (m_owner >= 0 && (!m_bvld || bus.m_tready)) er = 4'b1 << m_owner;
    chk($sformatf("rnd%0d_rdy", c), bus.s_tready, er);
    chk($sformatf("rnd%0d_mvld", c), bus.m_tvalid, m_bvld);
    chk($sformatf("rnd%0d_mdat", c), bus.m_tdata, m_bdat);
    chk($sformatf("rnd%0d_gvld", c), bus.grant_valid, m_owner >= 0);
    chk($sformatf("rnd%0d_gidx", c), bus.grant_idx, m_gidx);
    chk($sformatf("rnd%0d_tmo", c), bus.timeout_pulse, m_pulse);
  endtask

  task automatic model_step();
    bit acc;
    int pp;
    if (rst) begin
      m_reset();
      return;
    end
    m_pulse = 0;
    acc = (m_owner >= 0) && bus.s_tvalid[m_owner] && (!m_bvld || bus.m_tready);
    if (acc) begin
      m_bvld = 1;
      m_bdat = bus.s_tdata[m_owner*8 +: 8];
    end else if (bus.m_tready) begin
      m_bvld = 0;
    end
    if (m_owner < 0) begin
      for (int k = 1; k <= P; k++) begin
        pp = (m_last + k) % P;
        if (bus.s_tvalid[pp]) begin
          m_owner = pp; m_gidx = pp; m_idle = 0;
          break;
        end
      end
    end else if (acc) begin
      m_idle = 0;
      if (bus.s_tlast[m_owner]) begin
        m_last = m_owner; m_owner = -1;
      end
    end else if (!bus.s_tvalid[m_owner]) begin
      m_idle++;
      if (m_idle >= TMO) begin
        m_last = m_owner; m_owner = -1; m_pulse = 1;
      end
    end
  endtask

  logic [7:0] got[$];
  int         beat;
  logic [3:0] rv, rl;
  logic [31:0] rd;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(4'b0, 4'b0, 32'h0, 1'b1);
    tick();

    // Single 3-byte packet on port 0, then round-robin over ports 0,1,3 with 1-byte packets.
    vt.push_back(v(1, 4'b0001, 4'b0000, 32'h41, 1, 4'b0000, 0, 8'h00, 0, 0));
    vt.push_back(v(0, 4'b0001, 4'b0000, 32'h41, 1, 4'b0001, 0, 8'h00, 1, 0));
    vt.push_back(v(0, 4'b0001, 4'b0000, 32'h42, 1, 4'b0001, 1, 8'h41, 1, 0));
    vt.push_back(v(0, 4'b0001, 4'b0001, 32'h43, 1, 4'b0001, 1, 8'h42, 1, 0));
    vt.push_back(v(0, 4'b0000, 4'b0000, 32'h00, 1, 4'b0000, 1, 8'h43, 0, 0));
    vt.push_back(v(0, 4'b0000, 4'b0000, 32'h00, 1, 4'b0000, 0, 8'h43, 0, 0));
    vt.push_back(v(1, 4'b1011, 4'b1111, 32'h13121110, 1, 4'b0000, 0, 8'h00, 0, 0));
    vt.push_back(v(0, 4'b1011, 4'b1111, 32'h13121110, 1, 4'b0001, 0, 8'h00, 1, 0));
    vt.push_back(v(0, 4'b1011, 4'b1111, 32'h13121110, 1, 4'b0000, 1, 8'h10, 0, 0));
    vt.push_back(v(0, 4'b1011, 4'b1111, 32'h13121110, 1, 4'b0010, 0, 8'h10, 1, 1));
    vt.push_back(v(0, 4'b1011, 4'b1111, 32'h13121110, 1, 4'b0000, 1, 8'h11, 0, 1));
    vt.push_back(v(0, 4'b1011, 4'b1111, 32'h13121110, 1, 4'b1000, 0, 8'h11, 1, 3));
    vt.push_back(v(0, 4'b1011, 4'b1111, 32'h13121110, 1, 4'b0000, 1, 8'h13, 0, 3));
    vt.push_back(v(0, 4'b1011, 4'b1111, 32'h13121110, 1, 4'b0001, 0, 8'h13, 1, 0));
    vt.push_back(v(0, 4'b1011, 4'b1111, 32'h13121110, 1, 4'b0000, 1, 8'h10, 0, 0));
    vt.push_back(v(0, 4'b1011, 4'b1111, 32'h13121110, 1, 4'b0010, 0, 8'h10, 1, 1));
    vt.push_back(v(0, 4'b1011, 4'b1111, 32'h13121110, 1, 4'b0000, 1, 8'h11, 0, 1));
    vt.push_back(v(0, 4'b1011, 4'b1111, 32'h13121110, 1, 4'b1000, 0, 8'h11, 1, 3));
    vt.push_back(v(0, 4'b1011, 4'b1111, 32'h13121110, 1, 4'b0000, 1, 8'h13, 0, 3));

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].pre_rst) do_reset();
      drive(vt[i].vld, vt[i].last, vt[i].dat, vt[i].mrdy);
      #1;
      chk($sformatf("tbl%0d_rdy", i), bus.s_tready, vt[i].e_rdy);
      chk($sformatf("tbl%0d_mvld", i), bus.m_tvalid, vt[i].e_mvld);
      chk($sformatf("tbl%0d_mdat", i), bus.m_tdata, vt[i].e_mdat);
      chk($sformatf("tbl%0d_gvld", i), bus.grant_valid, vt[i].e_gvld);
      chk($sformatf("tbl%0d_gidx", i), bus.grant_idx, vt[i].e_gidx);
      chk($sformatf("tbl%0d_tmo", i), bus.timeout_pulse, 0);
      tick();
    end

    // Port 2 two-byte packet with m_tready toggling: nothing lost or duplicated.
    do_reset();
    got.delete();
    beat = 0;
    for (int c = 0; c < 10; c++) begin
      drive((beat < 2) ? 4'b0100 : 4'b0000, (beat == 1) ? 4'b0100 : 4'b0000,
            (beat == 0) ? 32'h00A00000 : 32'h00A10000, (c % 2) == 0);
      #1;
      if (bus.m_tvalid && bus.m_tready) got.push_back(bus.m_tdata);
      if (bus.m_tvalid && !bus.m_tready) chk($sformatf("stall%0d_rdy2", c), bus.s_tready[2], 0);
      if (bus.s_tvalid[2] && bus.s_tready[2]) beat++;
      tick();
    end
    chk("toggle_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("toggle_b0", got[0], 8'hA0);
      chk("toggle_b1", got[1], 8'hA1);
    end

    // Timeout: port 1 stalls mid-packet, port 2 is waiting.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      drive((c < 2) ? 4'b0110 : 4'b0100, 4'b0100, 32'h00775500, 1'b1);
      #1;
      if (c >= 1) chk($sformatf("tmo%0d_pulse", c), bus.timeout_pulse, c == 6);
      if (c == 5) chk("tmo5_gvld", bus.grant_valid, 1);
      if (c == 6) chk("tmo6_gvld", bus.grant_valid, 0);
      if (c == 7) begin
        chk("tmo7_gvld", bus.grant_valid, 1);
        chk("tmo7_gidx", bus.grant_idx, 2);
        chk("tmo7_rdy", bus.s_tready, 4'b0100);
      end
      if (c == 8) chk("tmo8_mdat", bus.m_tdata, 8'h77);
      tick();
    end

    // Reset in the middle of a 4-byte packet on port 3.
    do_reset();
    beat = 0;
    for (int c = 0; c < 6; c++) begin
      drive(4'b1000, 4'b0000, {8'hB0 + 8'(beat), 24'h0}, 1'b1);
      rst = (c == 3);
      #1;
      if (c == 3) begin
        chk("rst3_beats", beat, 2);
        chk("rst3_mdat", bus.m_tdata, 8'hB1);
      end
      if (c == 4) begin
        chk("rst4_mvld", bus.m_tvalid, 0);
        chk("rst4_mdat", bus.m_tdata, 0);
        chk("rst4_gvld", bus.grant_valid, 0);
        chk("rst4_rdy", bus.s_tready, 0);
      end
      if (c == 5) begin
        chk("rst5_gvld", bus.grant_valid, 1);
        chk("rst5_gidx", bus.grant_idx, 3);
        chk("rst5_rdy", bus.s_tready, 4'b1000);
      end
      if (bus.s_tvalid[3] && bus.s_tready[3] && !rst) beat++;
      tick();
    end
    rst = 1'b0;

    // Priority after reset: ports 0 and 3 both ask, port 0 must win.
    do_reset();
    drive(4'b1001, 4'b1001, 32'hD00000C0, 1'b1);
    tick();
    #1;
    chk("prio_gidx", bus.grant_idx, 0);
    chk("prio_rdy", bus.s_tready, 4'b0001);
    tick();

    // Randomized traffic against the reference model, with occasional resets.
    do_reset();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < P; p++) begin
        rv[p] = ($urandom_range(0, 99) < 60);
        rl[p] = ($urandom_range(0, 2) == 0);
      end
      rd = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      drive(rv, rl, rd, $urandom_range(0, 99) < 70);
      #1;
      model_check(c);
      model_step();
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
